// File: rtl/sm3_msg_expnd.sv
// ============================================================================
// sm3_msg_expnd
// ----------------------------------------------------------------------------
// SM3 message expansion. It collects one padded 512-bit block as 16 big-endian
// 32-bit words, then streams 64 expansion beats (W_j, W'_j), one per cycle,
// to the compression core.
//
// Ports
//   clk              : single clock, rising-edge state updates
//   rst_n            : asynchronous active-low reset
//   pad_inpt_data_i  : padded message word (word 0 of the block first)
//   pad_inpt_vld_i   : input word valid
//   pad_inpt_lst_i   : sampled only with word 15; flags the final block
//   pad_inpt_rdy_o   : high while loading; a word moves on vld & rdy
//   expnd_otpt_wj_o  : W_j
//   expnd_otpt_wjj_o : W'_j = W_j ^ W_(j+4)
//   expnd_otpt_lst_o : high on the round-63 beat of the final block
//   expnd_otpt_vld_o : beat valid, no backpressure
// ============================================================================
module sm3_msg_expnd (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] pad_inpt_data_i,
    input  logic        pad_inpt_vld_i,
    input  logic        pad_inpt_lst_i,
    output logic        pad_inpt_rdy_o,
    output logic [31:0] expnd_otpt_wj_o,
    output logic [31:0] expnd_otpt_wjj_o,
    output logic        expnd_otpt_lst_o,
    output logic        expnd_otpt_vld_o
);

    typedef enum logic {
        LOAD  = 1'b0,
        EXPND = 1'b1
    } state_t;

    state_t      state;
    state_t      state_nxt;

    // Sliding window: win[k] holds W_(j+k) for the beat j currently presented.
    logic [31:0] win [16];
    logic [3:0]  word_cnt;
    logic [5:0]  rnd_j;
    logic        blk_lst;

    logic        word_acc;
    logic        last_word_acc;
    logic        last_rnd;
    logic [31:0] w_new;

    function automatic logic [31:0] rotl7(input logic [31:0] x);
        return {x[24:0], x[31:25]};
    endfunction

    function automatic logic [31:0] rotl15(input logic [31:0] x);
        return {x[16:0], x[31:17]};
    endfunction

    function automatic logic [31:0] rotl23(input logic [31:0] x);
        return {x[8:0], x[31:9]};
    endfunction

    function automatic logic [31:0] p1(input logic [31:0] x);
        return x ^ rotl15(x) ^ rotl23(x);
    endfunction

    assign pad_inpt_rdy_o = (state == LOAD);
    assign word_acc       = (state == LOAD) && pad_inpt_vld_i;
    assign last_word_acc  = word_acc && (word_cnt == 4'd15);
    assign last_rnd       = (rnd_j == 6'd63);

    // W_(j+16) from the window holding W_j..W_(j+15).
    assign w_new = p1(win[0] ^ win[7] ^ rotl15(win[13])) ^ rotl7(win[3]) ^ win[10];

    // ------------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= LOAD;
        end else begin
            state <= state_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        case (state)
            LOAD: begin
                if (last_word_acc) begin
                    state_nxt = EXPND;
                end
            end
            EXPND: begin
                if (last_rnd) begin
                    state_nxt = LOAD;
                end
            end
            default: state_nxt = LOAD;
        endcase
    end

    // ------------------------------------------------------------------------
    // Window, counters and registered outputs.
    // Beat 0 is registered on the same edge that captures word 15: it only
    // needs W_0 and W_4, which are already in the window. That gives the
    // one-cycle fill-to-output latency while the outputs stay registered.
    // Each later edge in EXPND presents beat j+1 from win[1]/win[5] and
    // shifts the window so that win[0] becomes W_(j+1).
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < 16; i++) begin
                win[i] <= '0;
            end
            word_cnt         <= '0;
            rnd_j            <= '0;
            blk_lst          <= 1'b0;
            expnd_otpt_wj_o  <= '0;
            expnd_otpt_wjj_o <= '0;
            expnd_otpt_lst_o <= 1'b0;
            expnd_otpt_vld_o <= 1'b0;
        end else begin
            case (state)
                LOAD: begin
                    expnd_otpt_lst_o <= 1'b0;
                    expnd_otpt_vld_o <= last_word_acc;
                    if (word_acc) begin
                        win[word_cnt] <= pad_inpt_data_i;
                        word_cnt      <= word_cnt + 4'd1;
                    end
                    if (last_word_acc) begin
                        blk_lst          <= pad_inpt_lst_i;
                        rnd_j            <= '0;
                        expnd_otpt_wj_o  <= win[0];
                        expnd_otpt_wjj_o <= win[0] ^ win[4];
                    end
                end
                EXPND: begin
                    if (last_rnd) begin
                        rnd_j            <= '0;
                        expnd_otpt_vld_o <= 1'b0;
                        expnd_otpt_lst_o <= 1'b0;
                    end else begin
                        rnd_j            <= rnd_j + 6'd1;
                        expnd_otpt_vld_o <= 1'b1;
                        expnd_otpt_lst_o <= blk_lst && (rnd_j == 6'd62);
                        expnd_otpt_wj_o  <= win[1];
                        expnd_otpt_wjj_o <= win[1] ^ win[5];
                        for (int unsigned i = 0; i < 15; i++) begin
                            win[i] <= win[i + 1];
                        end
                        win[15] <= w_new;
                    end
                end
                default: begin
                    expnd_otpt_vld_o <= 1'b0;
                    expnd_otpt_lst_o <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sm3_msg_expnd.sv
// ============================================================================
// tb_sm3_msg_expnd
// ----------------------------------------------------------------------------
// Scoreboard bench for sm3_msg_expnd. The stimulus process pushes the
// expected beats of each block into a queue; the monitor pops and compares
// on every valid output beat.
// ============================================================================
module tb_sm3_msg_expnd;

    typedef logic [31:0] blk_t [16];
    typedef logic [31:0] wexp_t [68];
    typedef struct packed {
        logic [31:0] wj;
        logic [31:0] wjj;
        logic        lst;
    } beat_t;

    logic        clk;
    logic        rst_n;
    logic [31:0] in_data;
    logic        in_vld;
    logic        in_lst;
    logic        in_rdy;
    logic [31:0] out_wj;
    logic [31:0] out_wjj;
    logic        out_lst;
    logic        out_vld;

    sm3_msg_expnd dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .pad_inpt_data_i  (in_data),
        .pad_inpt_vld_i   (in_vld),
        .pad_inpt_lst_i   (in_lst),
        .pad_inpt_rdy_o   (in_rdy),
        .expnd_otpt_wj_o  (out_wj),
        .expnd_otpt_wjj_o (out_wjj),
        .expnd_otpt_lst_o (out_lst),
        .expnd_otpt_vld_o (out_vld)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int          n_chk = 0;
    int          n_pass = 0;
    beat_t       q [$];
    int          exp_first = -1;
    int          blk_beat = 0;
    int          blk_num = 0;
    bit          chk_hold = 0;
    logic [31:0] hold_wj = '0;
    logic [31:0] cap_wj0 = '0;
    logic [31:0] cap_wjj0 = '0;
    logic [31:0] cap_wj16 = '0;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
    endfunction

    function automatic logic [31:0] rl(input logic [31:0] x, input int n);
        return (x << n) | (x >> (32 - n));
    endfunction

    function automatic void expand(input blk_t b, output wexp_t w);
        logic [31:0] t;
        for (int n = 0; n < 16; n++) w[n] = b[n];
        for (int n = 16; n < 68; n++) begin
            t = w[n-16] ^ w[n-9] ^ rl(w[n-3], 15);
            w[n] = (t ^ rl(t, 15) ^ rl(t, 23)) ^ rl(w[n-13], 7) ^ w[n-6];
        end
    endfunction

    // ------------------------------------------------------------------------
    // Monitor
    // ------------------------------------------------------------------------
    always @(negedge clk) begin
        beat_t e;
        if (!rst_n) begin
            blk_beat = 0;
            chk_hold = 0;
        end else begin
            if (chk_hold) begin
                chk_hold = 0;
                chk("rdy_after_beat63", {31'd0, in_rdy}, 32'd1);
                chk("vld_after_beat63", {31'd0, out_vld}, 32'd0);
                chk("wj_hold_after_blk", out_wj, hold_wj);
            end
            if (out_vld) begin
                if (q.size() == 0) begin
                    n_chk++;
                    $display("FAIL extra_beat: got unexpected beat wj=0x%08h, expected none", out_wj);
                end else begin
                    e = q.pop_front();
                    chk("wj", out_wj, e.wj);
                    chk("wjj", out_wjj, e.wjj);
                    chk("lst", {31'd0, out_lst}, {31'd0, e.lst});
                    if (blk_beat == 0) chk("first_beat_cycle", cyc, exp_first);
                    if (blk_num == 0 && blk_beat == 0) begin
                        cap_wj0  = out_wj;
                        cap_wjj0 = out_wjj;
                    end
                    if (blk_num == 0 && blk_beat == 16) cap_wj16 = out_wj;
                    if (blk_beat == 63) begin
                        chk("rdy_on_beat63", {31'd0, in_rdy}, 32'd0);
                        chk_hold = 1;
                        hold_wj  = e.wj;
                    end
                end
                blk_beat++;
                if (blk_beat == 64) begin
                    blk_beat = 0;
                    blk_num++;
                end
            end
        end
    end

    // ------------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------------
    task automatic send_word(input logic [31:0] d, input logic l, input int idx);
        bit ok = 0;
        for (int t = 0; t < 200 && !ok; t++) begin
            @(negedge clk);
            in_vld  = 1'b1;
            in_data = d;
            in_lst  = l;
            if (in_rdy) begin
                ok = 1;
                if (idx == 15) exp_first = cyc + 1;
            end
        end
        if (!ok) begin
            n_chk++;
            $display("FAIL load_timeout: word %0d rdy stayed 0, expected 1", idx);
        end
    endtask

    task automatic send_block(input blk_t b, input int lst_idx, input int gap, input bit exp_lst);
        wexp_t w;
        beat_t e;
        expand(b, w);
        for (int j = 0; j < 64; j++) begin
            e.wj  = w[j];
            e.wjj = w[j] ^ w[j+4];
            e.lst = exp_lst && (j == 63);
            q.push_back(e);
        end
        for (int i = 0; i < 16; i++) begin
            for (int g = 0; g < gap; g++) begin
                @(negedge clk);
                in_vld = 1'b0;
                in_lst = 1'b0;
            end
            send_word(b[i], (i == lst_idx), i);
        end
        @(negedge clk);
        in_vld = 1'b0;
        in_lst = 1'b0;
    endtask

    task automatic drain();
        for (int t = 0; t < 400 && q.size() != 0; t++) @(negedge clk);
        repeat (3) @(negedge clk);
        chk("queue_drained", q.size(), 0);
    endtask

    blk_t blk_abc;
    blk_t blk_b;
    blk_t blk_c;

    initial begin
        for (int i = 0; i < 16; i++) begin
            blk_abc[i] = '0;
            blk_b[i]   = 32'h0123_4567 * (i + 1) ^ 32'hDEAD_BEEF;
            blk_c[i]   = {8'(i), 8'(i * 3), 8'(255 - i), 8'(i * 17)};
        end
        blk_abc[0]  = 32'h6162_6380;
        blk_abc[15] = 32'h0000_0018;

        rst_n   = 1'b0;
        in_vld  = 1'b0;
        in_lst  = 1'b0;
        in_data = '0;
        #3;
        chk("rst_vld", {31'd0, out_vld}, 32'd0);
        chk("rst_lst", {31'd0, out_lst}, 32'd0);
        chk("rst_rdy", {31'd0, in_rdy}, 32'd1);
        chk("rst_wj", out_wj, 32'd0);
        chk("rst_wjj", out_wjj, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // "abc" final block, then same block not final, then with vld gaps
        send_block(blk_abc, 15, 0, 1'b1);
        send_block(blk_abc, -1, 0, 1'b0);
        drain();
        send_block(blk_abc, 15, 2, 1'b1);
        drain();

        // back-to-back: non-final then final
        send_block(blk_b, -1, 0, 1'b0);
        send_block(blk_c, 15, 0, 1'b1);
        drain();

        // reset while presenting round 30
        send_block(blk_abc, 15, 0, 1'b1);
        for (int t = 0; t < 200 && blk_beat != 31; t++) begin
            @(negedge clk);
            #1;
        end
        chk("reached_beat30", blk_beat, 31);
        rst_n = 1'b0;
        #1;
        chk("abort_vld", {31'd0, out_vld}, 32'd0);
        chk("abort_lst", {31'd0, out_lst}, 32'd0);
        chk("abort_rdy", {31'd0, in_rdy}, 32'd1);
        q.delete();
        @(negedge clk);
        #1 rst_n = 1'b1;

        // reset in the middle of a load: the next word must be word 0
        for (int i = 0; i < 5; i++) send_word(32'hFFFF_0000 | i, 1'b0, i);
        @(negedge clk);
        in_vld = 1'b0;
        #1 rst_n = 1'b0;
        @(negedge clk);
        #1 rst_n = 1'b1;
        send_block(blk_b, 15, 0, 1'b1);
        drain();

        // lst on word 7 only must be ignored
        send_block(blk_abc, 7, 0, 1'b0);
        drain();

        chk("abc_beat0_wj", cap_wj0, 32'h6162_6380);
        chk("abc_beat0_wjj", cap_wjj0, 32'h6162_6380);
        chk("abc_beat16_wj", cap_wj16, 32'h9092_E200);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation time exceeded, expected completion");
        $fatal(1);
    end

endmodule
